// File: rtl/l2_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_bridge_pkg
// Description : Shared widths, defaults and FSM state encoding for the
//               L2-to-DRAM beat bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_mem_bridge_pkg;

    localparam int MEM_BEAT_BITS = 64;
    localparam int L2_LINE_BITS  = 512;
    localparam int MEM_BEATS     = L2_LINE_BITS / MEM_BEAT_BITS;
    localparam int MEM_TIMEOUT   = 1023;

    // One transaction in flight: accept, command, then either push or collect beats
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        RESP  = 3'd4
    } bridge_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_line_beat_buf.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_beat_buf
// Description : Line register with a beat-indexed read port (writeback path)
//               and a beat-indexed write port (refill path), plus the shared
//               beat counter. BEATS must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_line_beat_buf
    import l2_mem_bridge_pkg::*;
#(
    parameter  int BEATS = MEM_BEATS,
    localparam int CNT_W = $clog2(BEATS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_load,
    input  logic [BEATS*MEM_BEAT_BITS-1:0] i_load_data,
    input  logic                           i_cnt_clr,
    input  logic                           i_beat_wr,
    input  logic [MEM_BEAT_BITS-1:0]       i_beat_wdata,
    input  logic                           i_beat_adv,
    output logic [BEATS*MEM_BEAT_BITS-1:0] o_line,
    output logic [CNT_W-1:0]               o_cnt,
    output logic [MEM_BEAT_BITS-1:0]       o_beat_rdata
);

    logic [BEATS*MEM_BEAT_BITS-1:0] r_line;
    logic [CNT_W-1:0]               r_cnt;
    logic [CNT_W-1:0]               w_cnt_inc;

    // Wrap explicitly so non-power-of-two beat counts still index correctly
    assign w_cnt_inc = (r_cnt == CNT_W'(BEATS - 1)) ? '0 : r_cnt + 1'b1;

    // Whole-line load on request accept; single-beat overwrite on refill data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_load_data;
        end else if (i_beat_wr) begin
            r_line[int'(r_cnt)*MEM_BEAT_BITS +: MEM_BEAT_BITS] <= i_beat_wdata;
        end
    end

    // Beat index, stepped by either a written refill beat or a sent writeback beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (i_beat_wr || i_beat_adv) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign o_line       = r_line;
    assign o_cnt        = r_cnt;
    assign o_beat_rdata = r_line[int'(r_cnt)*MEM_BEAT_BITS +: MEM_BEAT_BITS];

endmodule
`default_nettype wire

// File: rtl/l2_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_bridge
// Description : Serialises single-line L2 requests onto a 64-bit DRAM beat
//               bus (one command + BEATS beats) and reassembles refill beats
//               into a line. One transaction outstanding; a watchdog bounds
//               the gap between refill beats.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_bridge
    import l2_mem_bridge_pkg::*;
#(
    parameter int BEATS   = MEM_BEATS,
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_req_valid_i,
    input  logic [31:0]                    mem_req_addr_i,
    input  logic                           mem_req_we_i,
    input  logic [BEATS*MEM_BEAT_BITS-1:0] mem_req_data_i,
    output logic                           mem_req_ready_o,
    output logic                           mem_resp_valid_o,
    output logic [BEATS*MEM_BEAT_BITS-1:0] mem_resp_data_o,
    output logic                           mem_resp_error_o,
    input  logic                           mem_resp_ready_i,
    output logic                           bus_cmd_valid_o,
    input  logic                           bus_cmd_ready_i,
    output logic [31:0]                    bus_cmd_addr_o,
    output logic                           bus_cmd_we_o,
    output logic                           bus_wvalid_o,
    input  logic                           bus_wready_i,
    output logic [MEM_BEAT_BITS-1:0]       bus_wdata_o,
    output logic                           bus_wlast_o,
    input  logic                           bus_rvalid_i,
    output logic                           bus_rready_o,
    input  logic [MEM_BEAT_BITS-1:0]       bus_rdata_i,
    input  logic                           bus_rerror_i,
    input  logic                           bus_rlast_i
);

    localparam int CNT_W = $clog2(BEATS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    bridge_state_e    r_state;
    bridge_state_e    w_state_nxt;
    logic [31:0]      r_addr;
    logic             r_we;
    logic             r_err;
    logic [WD_W-1:0]  r_wdog;
    logic [WD_W-1:0]  w_wdog_inc;
    logic [CNT_W-1:0] w_cnt;
    logic             w_last;
    logic             w_req_fire;
    logic             w_cmd_fire;
    logic             w_wbeat;
    logic             w_rbeat;
    logic             w_wdog_expire;

    assign w_last        = (w_cnt == CNT_W'(BEATS - 1));
    assign w_req_fire    = (r_state == IDLE)  && mem_req_valid_i;
    assign w_cmd_fire    = (r_state == CMD)   && bus_cmd_ready_i;
    assign w_wbeat       = (r_state == WDATA) && bus_wready_i;
    assign w_rbeat       = (r_state == RDATA) && bus_rvalid_i;
    assign w_wdog_inc    = (r_wdog == WD_W'(TIMEOUT)) ? r_wdog : r_wdog + 1'b1;
    // Abort on the edge where the idle count reaches TIMEOUT
    assign w_wdog_expire = (r_state == RDATA) && !bus_rvalid_i &&
                           (w_wdog_inc == WD_W'(TIMEOUT));

    mem_line_beat_buf #(
        .BEATS (BEATS)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_req_fire),
        .i_load_data  (mem_req_data_i),
        .i_cnt_clr    (w_req_fire || w_cmd_fire),
        .i_beat_wr    (w_rbeat),
        .i_beat_wdata (bus_rdata_i),
        .i_beat_adv   (w_wbeat),
        .o_line       (mem_resp_data_o),
        .o_cnt        (w_cnt),
        .o_beat_rdata (bus_wdata_o)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs, all decoded from registered state
    always_comb begin
        w_state_nxt      = r_state;
        mem_req_ready_o  = 1'b0;
        mem_resp_valid_o = 1'b0;
        bus_cmd_valid_o  = 1'b0;
        bus_wvalid_o     = 1'b0;
        bus_wlast_o      = 1'b0;
        bus_rready_o     = 1'b0;
        case (r_state)
            IDLE: begin
                mem_req_ready_o = 1'b1;
                if (mem_req_valid_i) w_state_nxt = CMD;
            end
            CMD: begin
                bus_cmd_valid_o = 1'b1;
                if (bus_cmd_ready_i) w_state_nxt = r_we ? WDATA : RDATA;
            end
            WDATA: begin
                bus_wvalid_o = 1'b1;
                bus_wlast_o  = w_last;
                if (bus_wready_i && w_last) w_state_nxt = IDLE;
            end
            RDATA: begin
                bus_rready_o = 1'b1;
                if ((bus_rvalid_i && w_last) || w_wdog_expire) w_state_nxt = RESP;
            end
            RESP: begin
                mem_resp_valid_o = 1'b1;
                if (mem_resp_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command fields captured at request accept; offset bits are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_we   <= 1'b0;
        end else if (w_req_fire) begin
            r_addr <= mem_req_addr_i & ~32'h0000_003F;
            r_we   <= mem_req_we_i;
        end
    end

    // Refill error flag and inter-beat watchdog, both restarted at the command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_wdog <= '0;
        end else if (w_cmd_fire) begin
            r_err  <= 1'b0;
            r_wdog <= '0;
        end else if (r_state == RDATA) begin
            if (bus_rvalid_i) begin
                r_wdog <= '0;
                r_err  <= r_err | bus_rerror_i | (bus_rlast_i != w_last);
            end else begin
                r_wdog <= w_wdog_inc;
                if (w_wdog_expire) r_err <= 1'b1;
            end
        end
    end

    assign bus_cmd_addr_o   = r_addr;
    assign bus_cmd_we_o     = r_we;
    assign mem_resp_error_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mem_bridge
// Description : Self-checking bench for l2_mem_bridge. Expected lines, beat
//               order, error flags and cycle timing are derived from the
//               transaction-level behaviour of the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mem_bridge;

    localparam int BEATS   = 8;
    localparam int TIMEOUT = 1023;
    localparam int LW      = BEATS * 64;

    logic          clk;
    logic          rst;
    logic          mem_req_valid_i;
    logic [31:0]   mem_req_addr_i;
    logic          mem_req_we_i;
    logic [LW-1:0] mem_req_data_i;
    logic          mem_req_ready_o;
    logic          mem_resp_valid_o;
    logic [LW-1:0] mem_resp_data_o;
    logic          mem_resp_error_o;
    logic          mem_resp_ready_i;
    logic          bus_cmd_valid_o;
    logic          bus_cmd_ready_i;
    logic [31:0]   bus_cmd_addr_o;
    logic          bus_cmd_we_o;
    logic          bus_wvalid_o;
    logic          bus_wready_i;
    logic [63:0]   bus_wdata_o;
    logic          bus_wlast_o;
    logic          bus_rvalid_i;
    logic          bus_rready_o;
    logic [63:0]   bus_rdata_i;
    logic          bus_rerror_i;
    logic          bus_rlast_i;

    int pass_cnt;
    int total_cnt;
    int cyc = 0;

    // Refill beat script for the current read
    logic [63:0] rd_beat    [BEATS];
    logic        rd_err     [BEATS];
    logic        rd_lastbad [BEATS];
    int          rd_gap     [BEATS];
    int          rd_n;

    l2_mem_bridge #(
        .BEATS   (BEATS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req_valid_i  (mem_req_valid_i),
        .mem_req_addr_i   (mem_req_addr_i),
        .mem_req_we_i     (mem_req_we_i),
        .mem_req_data_i   (mem_req_data_i),
        .mem_req_ready_o  (mem_req_ready_o),
        .mem_resp_valid_o (mem_resp_valid_o),
        .mem_resp_data_o  (mem_resp_data_o),
        .mem_resp_error_o (mem_resp_error_o),
        .mem_resp_ready_i (mem_resp_ready_i),
        .bus_cmd_valid_o  (bus_cmd_valid_o),
        .bus_cmd_ready_i  (bus_cmd_ready_i),
        .bus_cmd_addr_o   (bus_cmd_addr_o),
        .bus_cmd_we_o     (bus_cmd_we_o),
        .bus_wvalid_o     (bus_wvalid_o),
        .bus_wready_i     (bus_wready_i),
        .bus_wdata_o      (bus_wdata_o),
        .bus_wlast_o      (bus_wlast_o),
        .bus_rvalid_i     (bus_rvalid_i),
        .bus_rready_o     (bus_rready_o),
        .bus_rdata_i      (bus_rdata_i),
        .bus_rerror_i     (bus_rerror_i),
        .bus_rlast_i      (bus_rlast_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number; the value seen at a falling edge names the current cycle
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Present one request at the next point the bridge is ready; returns one cycle later
    task automatic send_req(input logic [31:0] addr, input logic we, input logic [LW-1:0] data);
        int w;
        w = 0;
        while (mem_req_ready_o !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        mem_req_valid_i = 1'b1;
        mem_req_addr_i  = addr;
        mem_req_we_i    = we;
        mem_req_data_i  = data;
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        mem_req_addr_i  = $urandom;
        mem_req_we_i    = 1'b0;
        mem_req_data_i  = rand_line();
    endtask

    // Play the refill script; t_last is the cycle in which the final scripted beat was taken
    task automatic drive_read_beats(output int t_last);
        int w;
        t_last = -1;
        for (int k = 0; k < rd_n; k++) begin
            bus_rvalid_i = 1'b0;
            for (int g = 0; g < rd_gap[k]; g++) @(negedge clk);
            w = 0;
            while (bus_rready_o !== 1'b1 && w < 64) begin
                @(negedge clk);
                w++;
            end
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rd_beat[k];
            bus_rerror_i = rd_err[k];
            bus_rlast_i  = (k == BEATS - 1) != rd_lastbad[k];
            t_last       = cyc;
            @(negedge clk);
        end
        bus_rvalid_i = 1'b0;
        bus_rerror_i = 1'b0;
        bus_rlast_i  = 1'b0;
    endtask

    task automatic wait_resp(output int rc);
        int w;
        w  = 0;
        rc = -1;
        while (w < TIMEOUT + 64) begin
            if (mem_resp_valid_o === 1'b1) begin
                rc = cyc;
                break;
            end
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_reset();
        total_cnt++;
        if (mem_req_ready_o !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", mem_req_ready_o);
        else pass_cnt++;
        total_cnt++;
        if ({mem_resp_valid_o, bus_cmd_valid_o, bus_wvalid_o, bus_rready_o} !== 4'b0000)
            $display("FAIL reset_valids: got %b want 0000",
                     {mem_resp_valid_o, bus_cmd_valid_o, bus_wvalid_o, bus_rready_o});
        else pass_cnt++;
        total_cnt++;
        if (mem_resp_data_o !== '0 || mem_resp_error_o !== 1'b0)
            $display("FAIL reset_resp: got data %h err %b want zero", mem_resp_data_o, mem_resp_error_o);
        else pass_cnt++;
        total_cnt++;
        if ({bus_cmd_addr_o, bus_cmd_we_o, bus_wdata_o, bus_wlast_o} !== '0)
            $display("FAIL reset_bus: got addr %h we %b wdata %h wlast %b want zero",
                     bus_cmd_addr_o, bus_cmd_we_o, bus_wdata_o, bus_wlast_o);
        else pass_cnt++;
    endtask

    task automatic test_write_zero_wait(input logic [31:0] addr, input logic [LW-1:0] data);
        logic [63:0] exp_beat;
        bit          saw_resp;
        saw_resp        = 1'b0;
        bus_cmd_ready_i = 1'b1;
        bus_wready_i    = 1'b1;
        send_req(addr, 1'b1, data);
        total_cnt++;
        if (bus_cmd_valid_o !== 1'b1 || bus_cmd_addr_o !== {addr[31:6], 6'h0} || bus_cmd_we_o !== 1'b1)
            $display("FAIL wr_cmd: got v%b addr %h we %b want v1 addr %h we 1",
                     bus_cmd_valid_o, bus_cmd_addr_o, bus_cmd_we_o, {addr[31:6], 6'h0});
        else pass_cnt++;
        @(negedge clk);
        for (int k = 0; k < BEATS; k++) begin
            exp_beat = data[k*64 +: 64];
            total_cnt++;
            if (bus_wvalid_o !== 1'b1 || bus_wdata_o !== exp_beat || bus_wlast_o !== (k == BEATS - 1))
                $display("FAIL wr_beat%0d: got v%b %h last %b want v1 %h last %b",
                         k, bus_wvalid_o, bus_wdata_o, bus_wlast_o, exp_beat, k == BEATS - 1);
            else pass_cnt++;
            if (mem_resp_valid_o === 1'b1) saw_resp = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (mem_req_ready_o !== 1'b1 || bus_wvalid_o !== 1'b0)
            $display("FAIL wr_done: got ready %b wvalid %b want 1 0", mem_req_ready_o, bus_wvalid_o);
        else pass_cnt++;
        total_cnt++;
        if (saw_resp || mem_resp_valid_o !== 1'b0)
            $display("FAIL wr_no_resp: got resp %b want 0", saw_resp | mem_resp_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_read(input string tag, input bit spec_data, input int err_beat,
                             input int bad_last_beat, input bit zero_gap);
        logic [31:0]   addr;
        logic [LW-1:0] exp_line;
        logic          exp_err;
        int            c0;
        int            t_last;
        int            rc;
        addr    = $urandom;
        exp_err = 1'b0;
        rd_n    = BEATS;
        for (int k = 0; k < BEATS; k++) begin
            rd_beat[k]    = spec_data ? (64'hA5A5_0000_0000_0000 | 64'(k)) : {$urandom, $urandom};
            rd_gap[k]     = zero_gap ? 0 : $urandom_range(0, 4);
            rd_err[k]     = (k == err_beat);
            rd_lastbad[k] = (k == bad_last_beat);
            exp_line[k*64 +: 64] = rd_beat[k];
            if (rd_err[k] || rd_lastbad[k]) exp_err = 1'b1;
        end
        bus_cmd_ready_i  = 1'b1;
        mem_resp_ready_i = 1'b0;
        c0 = cyc;
        send_req(addr, 1'b0, rand_line());
        total_cnt++;
        if (bus_cmd_valid_o !== 1'b1 || bus_cmd_addr_o !== {addr[31:6], 6'h0} || bus_cmd_we_o !== 1'b0)
            $display("FAIL %s_cmd: got v%b addr %h we %b want v1 addr %h we 0",
                     tag, bus_cmd_valid_o, bus_cmd_addr_o, bus_cmd_we_o, {addr[31:6], 6'h0});
        else pass_cnt++;
        drive_read_beats(t_last);
        wait_resp(rc);
        total_cnt++;
        if (rc != t_last + 1 || (zero_gap && rc != c0 + 10))
            $display("FAIL %s_latency: got resp cycle %0d want %0d", tag, rc,
                     zero_gap ? c0 + 10 : t_last + 1);
        else pass_cnt++;
        total_cnt++;
        if (mem_resp_data_o !== exp_line || mem_resp_error_o !== exp_err)
            $display("FAIL %s_resp: got %h err %b want %h err %b",
                     tag, mem_resp_data_o, mem_resp_error_o, exp_line, exp_err);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (mem_resp_valid_o !== 1'b1 || mem_resp_data_o !== exp_line ||
                mem_resp_error_o !== exp_err || mem_req_ready_o !== 1'b0)
                $display("FAIL %s_hold%0d: got v%b err %b ready %b want v1 err %b ready 0",
                         tag, i, mem_resp_valid_o, mem_resp_error_o, mem_req_ready_o, exp_err);
            else pass_cnt++;
        end
        mem_resp_ready_i = 1'b1;
        @(negedge clk);
        mem_resp_ready_i = 1'b0;
        total_cnt++;
        if (mem_req_ready_o !== 1'b1 || mem_resp_valid_o !== 1'b0)
            $display("FAIL %s_turnaround: got ready %b valid %b want 1 0",
                     tag, mem_req_ready_o, mem_resp_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_read_timeout();
        logic [LW-1:0] req;
        logic [LW-1:0] exp_line;
        int            t3;
        int            rc;
        req      = rand_line();
        exp_line = req;
        rd_n     = 4;
        for (int k = 0; k < BEATS; k++) begin
            rd_beat[k]    = {$urandom, $urandom};
            rd_gap[k]     = $urandom_range(0, 3);
            rd_err[k]     = 1'b0;
            rd_lastbad[k] = 1'b0;
            if (k < 4) exp_line[k*64 +: 64] = rd_beat[k];
        end
        bus_cmd_ready_i  = 1'b1;
        mem_resp_ready_i = 1'b0;
        send_req($urandom, 1'b0, req);
        drive_read_beats(t3);
        wait_resp(rc);
        total_cnt++;
        if (rc != t3 + TIMEOUT + 1)
            $display("FAIL timeout_cycle: got resp cycle %0d want %0d", rc, t3 + TIMEOUT + 1);
        else pass_cnt++;
        total_cnt++;
        if (mem_resp_data_o !== exp_line || mem_resp_error_o !== 1'b1)
            $display("FAIL timeout_resp: got %h err %b want %h err 1",
                     mem_resp_data_o, mem_resp_error_o, exp_line);
        else pass_cnt++;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
        total_cnt++;
        if (bus_rready_o !== 1'b0) $display("FAIL timeout_late_rready: got %b want 0", bus_rready_o);
        else pass_cnt++;
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        total_cnt++;
        if (mem_resp_valid_o !== 1'b1 || mem_resp_data_o !== exp_line)
            $display("FAIL timeout_late_beat: got v%b %h want v1 %h",
                     mem_resp_valid_o, mem_resp_data_o, exp_line);
        else pass_cnt++;
        mem_resp_ready_i = 1'b1;
        @(negedge clk);
        mem_resp_ready_i = 1'b0;
        total_cnt++;
        if (mem_req_ready_o !== 1'b1) $display("FAIL timeout_done: got ready %b want 1", mem_req_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic [LW-1:0] data;
        data            = rand_line();
        bus_cmd_ready_i = 1'b1;
        bus_wready_i    = 1'b1;
        send_req($urandom, 1'b1, data);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (bus_wvalid_o !== 1'b1 || bus_wdata_o !== data[3*64 +: 64])
            $display("FAIL rstwr_beat3: got v%b %h want v1 %h", bus_wvalid_o, bus_wdata_o, data[3*64 +: 64]);
        else pass_cnt++;
        bus_wready_i = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (bus_wvalid_o !== 1'b0 || mem_req_ready_o !== 1'b1 || bus_cmd_valid_o !== 1'b0 || bus_wlast_o !== 1'b0)
            $display("FAIL rstwr_idle: got wvalid %b ready %b cmd %b wlast %b want 0 1 0 0",
                     bus_wvalid_o, mem_req_ready_o, bus_cmd_valid_o, bus_wlast_o);
        else pass_cnt++;
        bus_wready_i = 1'b1;
    endtask

    task automatic test_cmd_backpressure();
        logic [31:0]   addr;
        logic [LW-1:0] data;
        int            k;
        int            n;
        addr            = $urandom;
        data            = rand_line();
        bus_cmd_ready_i = 1'b0;
        bus_wready_i    = 1'b0;
        send_req(addr, 1'b1, data);
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (bus_cmd_valid_o !== 1'b1 || bus_cmd_addr_o !== {addr[31:6], 6'h0} ||
                bus_cmd_we_o !== 1'b1 || mem_req_ready_o !== 1'b0)
                $display("FAIL cmdbp_hold%0d: got v%b addr %h we %b ready %b want v1 addr %h we 1 ready 0",
                         i, bus_cmd_valid_o, bus_cmd_addr_o, bus_cmd_we_o, mem_req_ready_o,
                         {addr[31:6], 6'h0});
            else pass_cnt++;
            @(negedge clk);
        end
        bus_cmd_ready_i = 1'b1;
        @(negedge clk);
        bus_cmd_ready_i = 1'b0;
        k = 0;
        n = 0;
        while (k < BEATS && n < 200) begin
            total_cnt++;
            if (bus_wvalid_o !== 1'b1 || bus_wdata_o !== data[k*64 +: 64] || bus_wlast_o !== (k == BEATS - 1))
                $display("FAIL wbp_beat%0d: got v%b %h last %b want v1 %h last %b",
                         k, bus_wvalid_o, bus_wdata_o, bus_wlast_o, data[k*64 +: 64], k == BEATS - 1);
            else pass_cnt++;
            bus_wready_i = 1'($urandom_range(0, 1));
            if (bus_wready_i) k++;
            @(negedge clk);
            n++;
        end
        bus_wready_i = 1'b0;
        total_cnt++;
        if (k != BEATS || mem_req_ready_o !== 1'b1 || bus_wvalid_o !== 1'b0)
            $display("FAIL wbp_done: got beats %0d ready %b wvalid %b want %0d 1 0",
                     k, mem_req_ready_o, bus_wvalid_o, BEATS);
        else pass_cnt++;
    endtask

    initial begin
        logic [LW-1:0] spec_line;
        pass_cnt         = 0;
        total_cnt        = 0;
        rst              = 1'b1;
        mem_req_valid_i  = 1'b0;
        mem_req_addr_i   = '0;
        mem_req_we_i     = 1'b0;
        mem_req_data_i   = '0;
        mem_resp_ready_i = 1'b0;
        bus_cmd_ready_i  = 1'b0;
        bus_wready_i     = 1'b0;
        bus_rvalid_i     = 1'b0;
        bus_rdata_i      = '0;
        bus_rerror_i     = 1'b0;
        bus_rlast_i      = 1'b0;
        for (int k = 0; k < BEATS; k++) spec_line[k*64 +: 64] = 64'(k);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_write_zero_wait(32'h0001_2345, spec_line);
        test_write_zero_wait($urandom, rand_line());
        test_read("rd_spec", 1'b1, -1, -1, 1'b0);
        test_read("rd_zero_gap", 1'b0, -1, -1, 1'b1);
        test_read("rd_rerror3", 1'b0, 3, -1, 1'b0);
        test_read("rd_rlast_early", 1'b0, -1, $urandom_range(0, BEATS - 2), 1'b0);
        test_read("rd_rlast_missing", 1'b0, -1, BEATS - 1, 1'b0);
        test_read_timeout();
        test_reset_mid_write();
        test_read("rd_after_reset", 1'b0, -1, -1, 1'b0);
        test_cmd_backpressure();
        test_write_zero_wait($urandom, rand_line());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
